// File: rtl/requant_relu6_vec.sv
// Multi-lane per-channel requantiser: multiply, bias, round/shift, optional ReLU6, zero-point, saturate.
// Three-stage pipeline with a shared stall; per-channel parameters live in an internal register table.
module requant_relu6_vec #(
    parameter int LANES   = 4,
    parameter int MAX_CH  = 256,
    parameter int DATA_W  = 8,
    parameter int ACC_W   = 32,
    parameter int MUL_W   = 32,
    parameter int BIAS_W  = 32,
    parameter int SHIFT_W = 6,
    parameter int GRP_W   = $clog2(MAX_CH / LANES)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        cfg_we,
    input  logic [$clog2(MAX_CH)-1:0]   cfg_ch,
    input  logic signed [MUL_W-1:0]     cfg_mul,
    input  logic signed [BIAS_W-1:0]    cfg_bias,
    input  logic [SHIFT_W-1:0]          cfg_shift,
    input  logic [GRP_W:0]              cfg_num_grp,
    input  logic                        relu6_en,
    input  logic signed [DATA_W-1:0]    relu6_max,
    input  logic                        round_en,
    input  logic signed [DATA_W-1:0]    out_zp,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic                        in_sof,
    input  logic [LANES*ACC_W-1:0]      in_acc,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [GRP_W-1:0]            out_grp,
    output logic [LANES*DATA_W-1:0]     out_q
);

    localparam int CH_W    = $clog2(MAX_CH);
    localparam int SCALE_W = ACC_W + MUL_W;
    localparam int S_W     = SCALE_W + 1;
    localparam int Z_W     = SCALE_W + 2;
    localparam logic signed [Z_W-1:0] Q_MAX = Z_W'(2 ** (DATA_W - 1) - 1);
    localparam logic signed [Z_W-1:0] Q_MIN = Z_W'(-(2 ** (DATA_W - 1)));

    function automatic logic signed [S_W-1:0] round_shift(input logic signed [S_W-1:0] s,
                                                          input logic [SHIFT_W-1:0] sh,
                                                          input logic rnd);
        logic signed [S_W-1:0] t;
        t = s;
        if (rnd && sh != '0) begin
            t = t + (S_W'(1) << (sh - 1'b1));
        end
        return t >>> sh;
    endfunction

    function automatic logic signed [S_W-1:0] relu_clamp(input logic signed [S_W-1:0] r,
                                                         input logic en,
                                                         input logic signed [DATA_W-1:0] mx);
        logic signed [S_W-1:0] res;
        res = r;
        if (en) begin
            if (r < 0) begin
                res = '0;
            end else if (r > S_W'(mx)) begin
                res = S_W'(mx);
            end
        end
        return res;
    endfunction

    function automatic logic signed [DATA_W-1:0] saturate(input logic signed [Z_W-1:0] z);
        logic signed [Z_W-1:0] res;
        res = z;
        if (z > Q_MAX) begin
            res = Q_MAX;
        end else if (z < Q_MIN) begin
            res = Q_MIN;
        end
        return DATA_W'(res);
    endfunction

    logic signed [MUL_W-1:0]  tbl_mul_q   [MAX_CH];
    logic signed [BIAS_W-1:0] tbl_bias_q  [MAX_CH];
    logic [SHIFT_W-1:0]       tbl_shift_q [MAX_CH];

    // A write lands at the clock edge, so a lookup in the same cycle still sees the old entry.
    always_ff @(posedge clk) begin
        if (cfg_we) begin
            tbl_mul_q[cfg_ch]   <= cfg_mul;
            tbl_bias_q[cfg_ch]  <= cfg_bias;
            tbl_shift_q[cfg_ch] <= cfg_shift;
        end
    end

    logic advance;
    logic accept;
    logic vld_p1_d, vld_p1_q, vld_p2_d, vld_p2_q, vld_p3_d, vld_p3_q;
    logic [GRP_W-1:0] gp_d, gp_q;
    logic [GRP_W-1:0] grp_p1_d, grp_p1_q, grp_p2_d, grp_p2_q, out_grp_d, out_grp_q;

    assign advance  = !vld_p3_q || out_ready;
    assign accept   = in_valid && advance;
    assign in_ready = advance;

    always_comb begin
        grp_p1_d = in_sof ? '0 : gp_q;
        gp_d     = gp_q;
        if (accept) begin
            gp_d = ({1'b0, grp_p1_d} == cfg_num_grp - 1'b1) ? '0 : grp_p1_d + 1'b1;
        end
    end

    always_comb begin
        vld_p1_d = vld_p1_q;
        vld_p2_d = vld_p2_q;
        vld_p3_d = vld_p3_q;
        if (advance) begin
            vld_p1_d = in_valid;
            vld_p2_d = vld_p1_q;
            vld_p3_d = vld_p2_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1_q <= 1'b0;
            vld_p2_q <= 1'b0;
            vld_p3_q <= 1'b0;
            gp_q     <= '0;
        end else begin
            vld_p1_q <= vld_p1_d;
            vld_p2_q <= vld_p2_d;
            vld_p3_q <= vld_p3_d;
            gp_q     <= gp_d;
        end
    end

    // Stage 1: table lookup and product
    logic signed [SCALE_W-1:0] m_p1_d    [LANES];
    logic signed [SCALE_W-1:0] m_p1_q    [LANES];
    logic signed [BIAS_W-1:0]  bias_p1_d [LANES];
    logic signed [BIAS_W-1:0]  bias_p1_q [LANES];
    logic [SHIFT_W-1:0]        sh_p1_d   [LANES];
    logic [SHIFT_W-1:0]        sh_p1_q   [LANES];
    logic [CH_W-1:0]           idx;
    logic signed [ACC_W-1:0]   acc_l;

    always_comb begin
        idx   = '0;
        acc_l = '0;
        for (int i = 0; i < LANES; i++) begin
            m_p1_d[i]    = '0;
            bias_p1_d[i] = '0;
            sh_p1_d[i]   = '0;
        end
        for (int i = 0; i < LANES; i++) begin
            idx          = CH_W'(grp_p1_d) * CH_W'(LANES) + CH_W'(i);
            acc_l        = in_acc[i*ACC_W +: ACC_W];
            m_p1_d[i]    = SCALE_W'(acc_l) * SCALE_W'(tbl_mul_q[idx]);
            bias_p1_d[i] = tbl_bias_q[idx];
            sh_p1_d[i]   = tbl_shift_q[idx];
        end
    end

    always_ff @(posedge clk) begin
        if (advance) begin
            for (int i = 0; i < LANES; i++) begin
                m_p1_q[i]    <= m_p1_d[i];
                bias_p1_q[i] <= bias_p1_d[i];
                sh_p1_q[i]   <= sh_p1_d[i];
            end
            grp_p1_q <= grp_p1_d;
        end
    end

    // Stage 2: bias, rounding and arithmetic shift
    logic signed [S_W-1:0] r_p2_d [LANES];
    logic signed [S_W-1:0] r_p2_q [LANES];

    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            r_p2_d[i] = round_shift(S_W'(m_p1_q[i]) + S_W'(bias_p1_q[i]), sh_p1_q[i], round_en);
        end
        grp_p2_d = grp_p1_q;
    end

    always_ff @(posedge clk) begin
        if (advance) begin
            for (int i = 0; i < LANES; i++) begin
                r_p2_q[i] <= r_p2_d[i];
            end
            grp_p2_q <= grp_p2_d;
        end
    end

    // Stage 3: clamp, zero point, saturate into the output register
    logic [LANES*DATA_W-1:0] out_q_d, out_q_q;

    always_comb begin
        out_q_d = '0;
        for (int i = 0; i < LANES; i++) begin
            out_q_d[i*DATA_W +: DATA_W] =
                saturate(Z_W'(relu_clamp(r_p2_q[i], relu6_en, relu6_max)) + Z_W'(out_zp));
        end
        out_grp_d = grp_p2_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_q_q   <= '0;
            out_grp_q <= '0;
        end else if (advance && vld_p2_q) begin
            out_q_q   <= out_q_d;
            out_grp_q <= out_grp_d;
        end
    end

    assign out_valid = vld_p3_q;
    assign out_q     = out_q_q;
    assign out_grp   = out_grp_q;

endmodule

// File: tb/tb_requant_relu6_vec.sv
// Self-checking bench for requant_relu6_vec: directed arithmetic cases plus randomized streams
// compared against a floor-division reference model and a channel-parameter table mirror.
module tb_requant_relu6_vec;

    localparam int LANES   = 4;
    localparam int MAX_CH  = 256;
    localparam int DATA_W  = 8;
    localparam int ACC_W   = 32;
    localparam int MUL_W   = 32;
    localparam int BIAS_W  = 32;
    localparam int SHIFT_W = 6;
    localparam int GRP_W   = 6;
    localparam int CH_W    = 8;

    logic                       clk = 1'b0;
    logic                       rst;
    logic                       cfg_we;
    logic [CH_W-1:0]            cfg_ch;
    logic signed [MUL_W-1:0]    cfg_mul;
    logic signed [BIAS_W-1:0]   cfg_bias;
    logic [SHIFT_W-1:0]         cfg_shift;
    logic [GRP_W:0]             cfg_num_grp;
    logic                       relu6_en;
    logic signed [DATA_W-1:0]   relu6_max;
    logic                       round_en;
    logic signed [DATA_W-1:0]   out_zp;
    logic                       in_valid;
    logic                       in_ready;
    logic                       in_sof;
    logic [LANES*ACC_W-1:0]     in_acc;
    logic                       out_valid;
    logic                       out_ready;
    logic [GRP_W-1:0]           out_grp;
    logic [LANES*DATA_W-1:0]    out_q;

    requant_relu6_vec #(
        .LANES(LANES), .MAX_CH(MAX_CH), .DATA_W(DATA_W), .ACC_W(ACC_W),
        .MUL_W(MUL_W), .BIAS_W(BIAS_W), .SHIFT_W(SHIFT_W), .GRP_W(GRP_W)
    ) dut (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_mul(cfg_mul),
        .cfg_bias(cfg_bias), .cfg_shift(cfg_shift), .cfg_num_grp(cfg_num_grp),
        .relu6_en(relu6_en), .relu6_max(relu6_max), .round_en(round_en), .out_zp(out_zp),
        .in_valid(in_valid), .in_ready(in_ready), .in_sof(in_sof), .in_acc(in_acc),
        .out_valid(out_valid), .out_ready(out_ready), .out_grp(out_grp), .out_q(out_q)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    logic signed [MUL_W-1:0]  tm_mul  [MAX_CH];
    logic signed [BIAS_W-1:0] tm_bias [MAX_CH];
    logic [SHIFT_W-1:0]       tm_sh   [MAX_CH];
    int m_gp = 0;

    logic [LANES*DATA_W-1:0] exp_q[$], obs_q[$];
    logic [GRP_W-1:0]        exp_g[$], obs_g[$];

    logic                    snap_vld, snap_rdy, snap_ordy, snap_acc;
    logic [LANES*DATA_W-1:0] snap_q;
    logic [GRP_W-1:0]        snap_grp;

    // Reference: exact value, floor(x / 2^sh) by division, then clamp/offset/saturate.
    function automatic logic signed [DATA_W-1:0] ref_lane(input logic signed [ACC_W-1:0] acc,
            input logic signed [MUL_W-1:0] mul, input logic signed [BIAS_W-1:0] bias,
            input int sh, input bit rnd, input bit relu,
            input logic signed [DATA_W-1:0] mx, input logic signed [DATA_W-1:0] zp);
        logic signed [127:0] s, d, q;
        s = acc;
        s = s * mul + bias;
        d = 128'sd1 <<< sh;
        if (rnd && sh > 0) s = s + d / 2;
        q = s / d;
        if ((s % d) != 0 && s < 0) q = q - 1;
        if (relu) begin
            if (q < 0) q = 0;
            if (q > mx) q = mx;
        end
        q = q + zp;
        if (q > 127) q = 127;
        if (q < -128) q = -128;
        return q[DATA_W-1:0];
    endfunction

    function automatic logic [LANES*DATA_W-1:0] ref_beat(input int g, input logic [LANES*ACC_W-1:0] acc);
        logic [LANES*DATA_W-1:0] r;
        int ch;
        r = '0;
        for (int i = 0; i < LANES; i++) begin
            ch = g * LANES + i;
            r[i*DATA_W +: DATA_W] = ref_lane(acc[i*ACC_W +: ACC_W], tm_mul[ch], tm_bias[ch],
                                             int'(tm_sh[ch]), round_en, relu6_en, relu6_max, out_zp);
        end
        return r;
    endfunction

    function automatic logic signed [ACC_W-1:0] rand_acc();
        if ($urandom_range(0, 3) == 0) return $urandom;
        return $urandom_range(0, 65535) - 32768;
    endfunction

    function automatic logic [LANES*ACC_W-1:0] rand_beat();
        logic [LANES*ACC_W-1:0] b;
        for (int i = 0; i < LANES; i++) b[i*ACC_W +: ACC_W] = rand_acc();
        return b;
    endfunction

    // One clock: sample at negedge, update the model on handshakes, drive again after posedge.
    task automatic step();
        int g;
        @(negedge clk);
        snap_vld  = out_valid;
        snap_q    = out_q;
        snap_grp  = out_grp;
        snap_rdy  = in_ready;
        snap_ordy = out_ready;
        snap_acc  = 1'b0;
        if (rst) begin
            m_gp = 0;
        end else begin
            if (in_valid && in_ready) begin
                g = in_sof ? 0 : m_gp;
                exp_q.push_back(ref_beat(g, in_acc));
                exp_g.push_back(GRP_W'(g));
                m_gp = (g + 1) % int'(cfg_num_grp);
                snap_acc = 1'b1;
            end
            if (out_valid && out_ready) begin
                obs_q.push_back(out_q);
                obs_g.push_back(out_grp);
            end
        end
        if (cfg_we) begin
            tm_mul[cfg_ch]  = cfg_mul;
            tm_bias[cfg_ch] = cfg_bias;
            tm_sh[cfg_ch]   = cfg_shift;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input int ch, input logic signed [MUL_W-1:0] mul,
                             input logic signed [BIAS_W-1:0] bias, input logic [SHIFT_W-1:0] sh);
        cfg_we    = 1'b1;
        cfg_ch    = CH_W'(ch);
        cfg_mul   = mul;
        cfg_bias  = bias;
        cfg_shift = sh;
        step();
        cfg_we = 1'b0;
    endtask

    task automatic cfg_random(input int n);
        for (int c = 0; c < n; c++)
            cfg_write(c, $urandom_range(0, 65535) - 32768, $urandom_range(0, 1 << 20) - (1 << 19),
                      SHIFT_W'($urandom_range(0, 40)));
    endtask

    task automatic drain(output bit ok);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 40 && obs_q.size() < exp_q.size(); k++) step();
        for (int k = 0; k < 3; k++) step();
        ok = (obs_q.size() == exp_q.size());
    endtask

    task automatic run_one(input logic signed [ACC_W-1:0] acc0, output logic [LANES*DATA_W-1:0] got,
                           output logic [LANES*DATA_W-1:0] want, output bit ok);
        in_acc = rand_beat();
        in_acc[ACC_W-1:0] = acc0;
        in_sof   = 1'b1;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        in_sof   = 1'b0;
        drain(ok);
        got  = '0;
        want = '1;
        if (ok && obs_q.size() == 1) begin
            got  = obs_q.pop_front();
            want = exp_q.pop_front();
            void'(obs_g.pop_front());
            void'(exp_g.pop_front());
        end else begin
            ok = 1'b0;
            obs_q.delete(); exp_q.delete(); obs_g.delete(); exp_g.delete();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        n_vec += 4;
        if (snap_vld !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid got %b want 0", snap_vld); end
        if (snap_q !== '0) begin n_bad++; $display("FAIL reset_out_q got %h want 0", snap_q); end
        if (snap_grp !== '0) begin n_bad++; $display("FAIL reset_out_grp got %0d want 0", snap_grp); end
        if (snap_rdy !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready got %b want 1", snap_rdy); end
        rst = 1'b0;
        step();
    endtask

    task automatic test_rounding();
        logic [LANES*DATA_W-1:0] got, want;
        bit ok;
        cfg_num_grp = 1;
        cfg_random(4);
        cfg_write(0, 3, 50, 4);
        for (int r = 0; r < 2; r++) begin
            round_en = r[0];
            run_one(100, got, want, ok);
            n_vec += 2;
            if (!ok || $signed(got[7:0]) !== ((r == 0) ? 8'sd21 : 8'sd22)) begin
                n_bad++; $display("FAIL round%0d_lane0 got %0d want %0d ok=%0d", r, $signed(got[7:0]), (r == 0) ? 21 : 22, ok);
            end
            if (got !== want) begin n_bad++; $display("FAIL round%0d_beat got %h want %h", r, got, want); end
        end
    endtask

    task automatic test_relu();
        logic [LANES*DATA_W-1:0] got, want;
        bit ok;
        round_en = 1'b1;
        relu6_max = 6;
        for (int r = 0; r < 2; r++) begin
            relu6_en = r[0];
            run_one(-100, got, want, ok);
            n_vec += 2;
            if (!ok || $signed(got[7:0]) !== ((r == 0) ? -8'sd16 : 8'sd0)) begin
                n_bad++; $display("FAIL relu%0d_lane0 got %0d want %0d ok=%0d", r, $signed(got[7:0]), (r == 0) ? -16 : 0, ok);
            end
            if (got !== want) begin n_bad++; $display("FAIL relu%0d_beat got %h want %h", r, got, want); end
        end
    endtask

    task automatic test_saturate();
        logic [LANES*DATA_W-1:0] got, want;
        logic signed [ACC_W-1:0] acc_tab [3] = '{1000, -1000, 1000};
        logic signed [DATA_W-1:0] req_tab [3] = '{127, -128, -122};
        bit ok;
        cfg_write(0, 1, 0, 0);
        for (int k = 0; k < 3; k++) begin
            relu6_en = (k == 2);
            out_zp   = (k == 2) ? -8'sd128 : 8'sd0;
            run_one(acc_tab[k], got, want, ok);
            n_vec += 2;
            if (!ok || $signed(got[7:0]) !== req_tab[k]) begin
                n_bad++; $display("FAIL sat%0d_lane0 got %0d want %0d ok=%0d", k, $signed(got[7:0]), req_tab[k], ok);
            end
            if (got !== want) begin n_bad++; $display("FAIL sat%0d_beat got %h want %h", k, got, want); end
        end
        relu6_en = 1'b0;
        out_zp   = 0;
    endtask

    task automatic test_groups();
        int seq [12] = '{0, 1, 2, 0, 1, 2, 0, 1, 2, 0, 1, 2};
        logic [LANES*DATA_W-1:0] a, e;
        logic [GRP_W-1:0] ag, eg;
        bit ok;
        cfg_num_grp = 3;
        cfg_random(12);
        round_en = $urandom_range(0, 1);
        for (int b = 0; b < 12; b++) begin
            in_valid = 1'b1;
            in_sof   = (b == 0) || (b == 9);
            in_acc   = rand_beat();
            step();
        end
        in_sof = 1'b0;
        drain(ok);
        n_vec++;
        if (!ok || obs_q.size() != 12) begin n_bad++; $display("FAIL grp_count got %0d want 12", obs_q.size()); end
        for (int b = 0; b < 12 && obs_q.size() > 0 && exp_q.size() > 0; b++) begin
            a = obs_q.pop_front(); e = exp_q.pop_front();
            ag = obs_g.pop_front(); eg = exp_g.pop_front();
            n_vec += 2;
            if (ag !== GRP_W'(seq[b]) || ag !== eg) begin n_bad++; $display("FAIL grp_id%0d got %0d want %0d", b, ag, seq[b]); end
            if (a !== e) begin n_bad++; $display("FAIL grp_beat%0d got %h want %h", b, a, e); end
        end
        obs_q.delete(); exp_q.delete(); obs_g.delete(); exp_g.delete();
    endtask

    task automatic test_latency();
        int n;
        bit found, ok;
        logic [LANES*DATA_W-1:0] a, e;
        cfg_num_grp = 1;
        out_ready = 1'b1;
        in_acc   = rand_beat();
        in_sof   = 1'b1;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        in_sof   = 1'b0;
        n = 0;
        found = 1'b0;
        for (int k = 0; k < 10 && !found; k++) begin
            step();
            n++;
            if (snap_vld) found = 1'b1;
        end
        n_vec++;
        if (!found || n != 3) begin n_bad++; $display("FAIL latency got %0d want 3 found=%0d", n, found); end
        drain(ok);
        n_vec++;
        if (!ok || obs_q.size() != 1) begin
            n_bad++; $display("FAIL latency_beat_count got %0d want 1", obs_q.size());
        end else begin
            a = obs_q.pop_front(); e = exp_q.pop_front();
            if (a !== e) begin n_bad++; $display("FAIL latency_beat got %h want %h", a, e); end
        end
        obs_q.delete(); exp_q.delete(); obs_g.delete(); exp_g.delete();
    endtask

    task automatic test_backpressure();
        int sent;
        bit prev_stall, ok;
        logic [LANES*DATA_W-1:0] pq, a, e;
        logic [GRP_W-1:0] pg, ag, eg;
        cfg_num_grp = 3;
        relu6_en  = 1'b1;
        relu6_max = 8'sd100;
        out_zp    = -8'sd20;
        sent = 0;
        prev_stall = 1'b0;
        pq = '0;
        pg = '0;
        for (int cyc = 0; cyc < 3000 && sent < 64; cyc++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_sof    = ($urandom_range(0, 15) == 0);
            in_acc    = rand_beat();
            out_ready = $urandom_range(0, 1);
            step();
            if (prev_stall) begin
                n_vec++;
                if (!snap_vld || snap_q !== pq || snap_grp !== pg) begin
                    n_bad++; $display("FAIL bp_stable got v=%b q=%h g=%0d want v=1 q=%h g=%0d", snap_vld, snap_q, snap_grp, pq, pg);
                end
            end
            prev_stall = snap_vld && !snap_ordy;
            pq = snap_q;
            pg = snap_grp;
            if (snap_acc) sent++;
        end
        in_sof = 1'b0;
        drain(ok);
        n_vec++;
        if (!ok || obs_q.size() != 64) begin n_bad++; $display("FAIL bp_count got %0d want 64", obs_q.size()); end
        for (int b = 0; obs_q.size() > 0 && exp_q.size() > 0; b++) begin
            a = obs_q.pop_front(); e = exp_q.pop_front();
            ag = obs_g.pop_front(); eg = exp_g.pop_front();
            n_vec++;
            if (a !== e || ag !== eg) begin n_bad++; $display("FAIL bp_beat%0d got %h/%0d want %h/%0d", b, a, ag, e, eg); end
        end
        obs_q.delete(); exp_q.delete(); obs_g.delete(); exp_g.delete();
        relu6_en = 1'b0;
        out_zp   = 0;
    endtask

    task automatic test_collision();
        logic [LANES*DATA_W-1:0] a0, a1, e0, e1;
        bit ok;
        cfg_num_grp = 1;
        round_en = 1'b0;
        cfg_write(1, 2, 0, 2);
        in_acc = rand_beat();
        in_acc[ACC_W +: ACC_W] = 20;
        in_sof   = 1'b1;
        in_valid = 1'b1;
        cfg_we = 1'b1; cfg_ch = 1; cfg_mul = 5; cfg_bias = 0; cfg_shift = 2;
        step();
        cfg_we = 1'b0;
        step();
        drain(ok);
        n_vec++;
        if (!ok || obs_q.size() != 2) begin
            n_bad++; $display("FAIL coll_count got %0d want 2", obs_q.size());
        end else begin
            a0 = obs_q.pop_front(); a1 = obs_q.pop_front();
            e0 = exp_q.pop_front(); e1 = exp_q.pop_front();
            n_vec += 4;
            if ($signed(a0[15:8]) !== 8'sd10) begin n_bad++; $display("FAIL coll_old got %0d want 10", $signed(a0[15:8])); end
            if ($signed(a1[15:8]) !== 8'sd25) begin n_bad++; $display("FAIL coll_new got %0d want 25", $signed(a1[15:8])); end
            if (a0 !== e0) begin n_bad++; $display("FAIL coll_beat0 got %h want %h", a0, e0); end
            if (a1 !== e1) begin n_bad++; $display("FAIL coll_beat1 got %h want %h", a1, e1); end
        end
        in_sof = 1'b0;
        obs_q.delete(); exp_q.delete(); obs_g.delete(); exp_g.delete();
    endtask

    task automatic test_reset_midstream();
        logic [LANES*DATA_W-1:0] a, e;
        logic [GRP_W-1:0] ag;
        bit ok;
        cfg_num_grp = 3;
        cfg_random(12);
        out_ready = 1'b1;
        for (int b = 0; b < 3; b++) begin
            in_valid = 1'b1;
            in_sof   = (b == 0);
            in_acc   = rand_beat();
            step();
        end
        in_valid  = 1'b0;
        in_sof    = 1'b0;
        out_ready = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        exp_q.delete(); exp_g.delete(); obs_q.delete(); obs_g.delete();
        for (int k = 0; k < 4; k++) begin
            step();
            n_vec++;
            if (snap_vld !== 1'b0) begin n_bad++; $display("FAIL rst_mid_valid%0d got %b want 0", k, snap_vld); end
        end
        in_acc   = rand_beat();
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        drain(ok);
        n_vec++;
        if (!ok || obs_q.size() != 1) begin
            n_bad++; $display("FAIL rst_mid_count got %0d want 1", obs_q.size());
        end else begin
            a = obs_q.pop_front(); e = exp_q.pop_front();
            ag = obs_g.pop_front();
            n_vec += 2;
            if (ag !== '0) begin n_bad++; $display("FAIL rst_mid_grp got %0d want 0", ag); end
            if (a !== e) begin n_bad++; $display("FAIL rst_mid_beat got %h want %h", a, e); end
        end
        obs_q.delete(); exp_q.delete(); obs_g.delete(); exp_g.delete();
    endtask

    initial begin
        rst = 1'b1; cfg_we = 1'b0; cfg_ch = '0; cfg_mul = '0; cfg_bias = '0; cfg_shift = '0;
        cfg_num_grp = 1; relu6_en = 1'b0; relu6_max = 6; round_en = 1'b0; out_zp = 0;
        in_valid = 1'b0; in_sof = 1'b0; in_acc = '0; out_ready = 1'b1;
        @(posedge clk);
        #1;
        test_reset();
        test_rounding();
        test_relu();
        test_saturate();
        test_groups();
        test_latency();
        test_backpressure();
        test_collision();
        test_reset_midstream();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
